// File: rtl/moore_seq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : moore_seq_sched
//  Description : Round-robin scheduler that lends a shared 8-state Moore
//                sequence generator to one of N_REQ requesters at a time.
//                The owner gets a run of Length states starting at
//                Start_State, a one-cycle Done pulse, and must then drop its
//                request (four-phase release) before re-arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_sched #(
  parameter int N_REQ   = 4,
  parameter int STATE_W = 3,
  parameter int LEN_W   = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*STATE_W-1:0]   Start_State,
  input  logic [N_REQ*LEN_W-1:0]     Length,
  input  logic                       Abort,
  output logic [N_REQ-1:0]           Grant,
  output logic [STATE_W-1:0]         Seq_State,
  output logic                       Seq_Valid,
  output logic [N_REQ-1:0]           Done,
  output logic [1:0]                 Ctrl_State
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;        // current owner
  logic [IDX_W-1:0]   ptr;        // last served requester
  logic [STATE_W-1:0] cur;        // sequence state, drives Seq_State
  logic [LEN_W-1:0]   rem;        // steps left including the current one

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [STATE_W-1:0] pick_start;
  logic [LEN_W-1:0]   pick_len;
  logic [N_REQ-1:0]   owner;      // one-hot decode of idx
  logic               owner_req;

  // Round-robin search: first set Req bit starting at ptr+1, wrapping.
  // Constant bit selects keep the search free of variable-width indexing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_valid && Req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Per-requester field selection for the winner and the current owner.
  always_comb begin
    pick_start = '0;
    pick_len   = '0;
    owner      = '0;
    owner_req  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_start = Start_State[i*STATE_W +: STATE_W];
        pick_len   = Length[i*LEN_W +: LEN_W];
      end
      if (idx == IDX_W'(i)) begin
        owner[i]  = 1'b1;
        owner_req = Req[i];
      end
    end
  end

  // Controller state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore output decode (registers only).
  always_comb begin
    state_nxt  = state;
    Grant      = '0;
    Done       = '0;
    Seq_Valid  = 1'b0;
    Seq_State  = cur;
    Ctrl_State = state;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = (pick_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        Grant     = owner;
        Seq_Valid = 1'b1;
        if ((rem == LEN_W'(1)) || Abort) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Grant     = owner;
        Done      = owner;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run datapath: latch the winner, step the sequence, remember who was served.
  // cur only advances while another step follows, so Seq_State keeps showing
  // the last emitted state once the run is over.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx <= '0;
      ptr <= IDX_W'(N_REQ - 1);
      cur <= '0;
      rem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx <= pick_idx;
            rem <= pick_len;
            if (pick_len != '0) begin
              cur <= pick_start;
            end
          end
        end
        RUN: begin
          rem <= rem - LEN_W'(1);
          if (state_nxt == RUN) begin
            cur <= cur + STATE_W'(1);
          end
        end
        DONE: begin
          ptr <= idx;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moore_seq_sched
//  Description : Self-checking bench for moore_seq_sched (N_REQ=4, STATE_W=3,
//                LEN_W=4). Expected sequence states and grant order are
//                queued when stimulus is applied and popped as the DUT
//                produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_seq_sched;

  logic        Clk;
  logic        Reset;
  logic [3:0]  Req;
  logic [11:0] Start_State;
  logic [15:0] Length;
  logic        Abort;
  logic [3:0]  Grant;
  logic [2:0]  Seq_State;
  logic        Seq_Valid;
  logic [3:0]  Done;
  logic [1:0]  Ctrl_State;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  logic [3:0] gnt_q[$];

  moore_seq_sched #(.N_REQ(4), .STATE_W(3), .LEN_W(4)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Req         (Req),
    .Start_State (Start_State),
    .Length      (Length),
    .Abort       (Abort),
    .Grant       (Grant),
    .Seq_State   (Seq_State),
    .Seq_Valid   (Seq_Valid),
    .Done        (Done),
    .Ctrl_State  (Ctrl_State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock and land 1 ns after the edge.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    Req   = '0;
    Abort = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Start_State = '0;
    Length      = '0;
    do_reset();
    checks++; if (Grant !== 4'b0) begin failures++; $display("FAIL reset_grant: got %b want 0000", Grant); end
    checks++; if (Done !== 4'b0) begin failures++; $display("FAIL reset_done: got %b want 0000", Done); end
    checks++; if (Seq_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", Seq_Valid); end
    checks++; if (Seq_State !== 3'd0) begin failures++; $display("FAIL reset_seq_state: got %0d want 0", Seq_State); end
    checks++; if (Ctrl_State !== 2'd0) begin failures++; $display("FAIL reset_ctrl: got %0d want 0", Ctrl_State); end
  endtask

  task automatic test_basic_run;
    int  nv;
    bit  got;
    logic [2:0] e;
    nv = 0; got = 0;
    Start_State[0 +: 3] = 3'd5;
    Length[0 +: 4]      = 4'd4;
    exp_q = {};
    exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    exp_q.push_back(3'd7); exp_q.push_back(3'd0);
    Req = 4'b0001;
    tick();
    checks++; if (Ctrl_State !== 2'd1) begin failures++; $display("FAIL basic_start_latency: ctrl got %0d want 1", Ctrl_State); end
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      if (Seq_Valid) begin
        nv++;
        checks++; if (Grant !== 4'b0001) begin failures++; $display("FAIL basic_grant: got %b want 0001", Grant); end
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL basic_extra_valid: got state %0d want none", Seq_State);
        end else begin
          e = exp_q.pop_front();
          checks++; if (Seq_State !== e) begin failures++; $display("FAIL basic_state: got %0d want %0d", Seq_State, e); end
        end
      end else if (Done != 4'b0) begin
        got = 1;
        checks++; if (Done !== 4'b0001) begin failures++; $display("FAIL basic_done: got %b want 0001", Done); end
        checks++; if (Grant !== 4'b0001) begin failures++; $display("FAIL basic_done_grant: got %b want 0001", Grant); end
        checks++; if (Ctrl_State !== 2'd2) begin failures++; $display("FAIL basic_done_ctrl: got %0d want 2", Ctrl_State); end
        checks++; if (nv !== 4) begin failures++; $display("FAIL basic_valid_count: got %0d want 4", nv); end
        Req = 4'b0000;
      end
      if (!got) tick();
    end
    if (!got) begin checks++; failures++; $display("FAIL basic_timeout: got no Done want Done"); end
    tick();
    checks++; if (Ctrl_State !== 2'd3) begin failures++; $display("FAIL basic_wait_ctrl: got %0d want 3", Ctrl_State); end
    checks++; if ((Grant | Done) !== 4'b0) begin failures++; $display("FAIL basic_wait_outputs: got %b/%b want 0000/0000", Grant, Done); end
    tick();
    checks++; if (Ctrl_State !== 2'd0) begin failures++; $display("FAIL basic_idle_ctrl: got %0d want 0", Ctrl_State); end
  endtask

  task automatic test_round_robin;
    logic [3:0] prev, expg, rer;
    int glen, gap, ngr, rcnt;
    bit fin;
    prev = '0; rer = '0; glen = 0; gap = 0; ngr = 0; rcnt = 0; fin = 0;
    do_reset();
    Length      = 16'h2222;
    Start_State = 12'o3210;
    gnt_q = {};
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b0100); gnt_q.push_back(4'b1000);
    gnt_q.push_back(4'b0001);
    Req = 4'b1111;
    tick();
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (Grant != 4'b0) begin
        if (prev == 4'b0) begin
          if (gnt_q.size() == 0) begin
            checks++; failures++; $display("FAIL rr_extra_grant: got %b want none", Grant);
          end else begin
            expg = gnt_q.pop_front();
            checks++; if (Grant !== expg) begin failures++; $display("FAIL rr_order: got %b want %b", Grant, expg); end
          end
          if (ngr > 0) begin
            checks++; if (gap !== 2) begin failures++; $display("FAIL rr_gap: got %0d want 2", gap); end
          end
          ngr++;
          glen = 0;
        end
        glen++;
      end else begin
        if (prev != 4'b0) begin
          checks++; if (glen !== 3) begin failures++; $display("FAIL rr_grant_len: got %0d want 3", glen); end
          gap = 1;
          if (ngr == 5) fin = 1;
        end else begin
          gap++;
        end
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) Req = Req | rer;
      end
      if (Done != 4'b0) begin
        Req  = Req & ~Done;
        rer  = Done;
        rcnt = 2;
      end
      prev = Grant;
      if (!fin) tick();
    end
    if (!fin) begin checks++; failures++; $display("FAIL rr_timeout: got %0d grants want 5", ngr); end
    Req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_len_zero;
    Length[8 +: 4] = 4'd0;
    Req = 4'b0100;
    tick();
    checks++; if (Grant !== 4'b0100) begin failures++; $display("FAIL len0_grant: got %b want 0100", Grant); end
    checks++; if (Done !== 4'b0100) begin failures++; $display("FAIL len0_done: got %b want 0100", Done); end
    checks++; if (Seq_Valid !== 1'b0) begin failures++; $display("FAIL len0_valid: got %b want 0", Seq_Valid); end
    Req = 4'b0000;
    tick();
    checks++; if ((Grant | Done) !== 4'b0) begin failures++; $display("FAIL len0_single_cycle: got %b/%b want 0000/0000", Grant, Done); end
    tick();
  endtask

  task automatic test_abort;
    int nv;
    bit got;
    logic [2:0] e;
    nv = 0; got = 0;
    Start_State[0 +: 3] = 3'd0;
    Length[0 +: 4]      = 4'd10;
    exp_q = {};
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    Req = 4'b0001;
    tick();
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      if (Seq_Valid) begin
        nv++;
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL abort_extra_valid: got state %0d want none", Seq_State);
        end else begin
          e = exp_q.pop_front();
          checks++; if (Seq_State !== e) begin failures++; $display("FAIL abort_state: got %0d want %0d", Seq_State, e); end
        end
        if (nv == 3) Abort = 1'b1;
      end else if (Done != 4'b0) begin
        got = 1;
        checks++; if (Done !== 4'b0001) begin failures++; $display("FAIL abort_done: got %b want 0001", Done); end
        checks++; if (nv !== 3) begin failures++; $display("FAIL abort_valid_count: got %0d want 3", nv); end
        Abort = 1'b0;
        Req   = 4'b0000;
      end
      if (!got) tick();
    end
    if (!got) begin checks++; failures++; $display("FAIL abort_timeout: got no Done want Done"); end
    Abort = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    Length[0 +: 4] = 4'd5;
    Start_State[0 +: 3] = 3'd3;
    Req = 4'b0001;
    tick();
    tick();
    checks++; if (Seq_Valid !== 1'b1) begin failures++; $display("FAIL rst_mid_in_run: got valid %b want 1", Seq_Valid); end
    Reset = 1'b1;
    Req   = 4'b0000;
    tick();
    Reset = 1'b0;
    checks++; if ({Grant, Done, Seq_Valid, Seq_State, Ctrl_State} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs: got g=%b d=%b v=%b s=%0d c=%0d want all 0", Grant, Done, Seq_Valid, Seq_State, Ctrl_State);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Done !== 4'b0 || Ctrl_State !== 2'd0) begin failures++; $display("FAIL rst_mid_no_done: got d=%b c=%0d want 0000/0", Done, Ctrl_State); end
    end
    Length[0 +: 4] = 4'd1;
    Req = 4'b0011;
    tick();
    checks++; if (Grant !== 4'b0001) begin failures++; $display("FAIL rst_mid_regrant: got %b want 0001", Grant); end
    do_reset();
  endtask

  task automatic test_hold_req;
    Length[0 +: 4] = 4'd1;
    Req = 4'b0001;
    tick();
    tick();
    checks++; if (Done !== 4'b0001) begin failures++; $display("FAIL hold_done: got %b want 0001", Done); end
    Req = 4'b0111;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (Ctrl_State !== 2'd3 || Grant !== 4'b0) begin failures++; $display("FAIL hold_wait: got c=%0d g=%b want 3/0000", Ctrl_State, Grant); end
      tick();
    end
    Req = 4'b0110;
    tick();
    checks++; if (Ctrl_State !== 2'd0 || Grant !== 4'b0) begin failures++; $display("FAIL hold_idle: got c=%0d g=%b want 0/0000", Ctrl_State, Grant); end
    tick();
    checks++; if (Grant !== 4'b0010) begin failures++; $display("FAIL hold_resume: got %b want 0010", Grant); end
    do_reset();
  endtask

  initial begin
    Reset = 1'b1; Req = '0; Abort = 1'b0; Start_State = '0; Length = '0;
    test_reset();
    test_basic_run();
    test_round_robin();
    test_len_zero();
    test_abort();
    test_reset_mid_run();
    test_hold_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/moore_seq_sched.md
# moore_seq_sched

Scheduler that shares the 8-state Moore sequence generator among up to N_REQ requesters. A round-robin arbiter picks one requester, then sequences the generator through a requested run: a start state and a run length. The block emits the state stream with a valid strobe, signals completion per requester and waits for a four-phase release before re-arbitrating. It sits between the requesting control blocks and the shared sequence-driven datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- STATE_W, 3, state code width; sequence wraps modulo 2^STATE_W
- LEN_W, 4, run-length field width
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  N_REQ  level request per requester; held high until Done seen
- Start_State  in  N_REQ*STATE_W  first state of run; slice i = bits [i*STATE_W +: STATE_W]
- Length  in  N_REQ*LEN_W  states to emit; slice i = bits [i*LEN_W +: LEN_W]
- Abort  in  1  terminate current run early
- Grant  out  N_REQ  one-hot grant, zero when no owner
- Seq_State  out  STATE_W  current sequence state driven to datapath
- Seq_Valid  out  1  Seq_State is a live step of the run
- Done  out  N_REQ  one-cycle completion pulse to owner
- Ctrl_State  out  2  controller state for bench visibility

## Operation
- Controller states: IDLE=0, RUN=1, DONE=2, WAIT=3; Ctrl_State mirrors them.
- IDLE: Grant=0, Seq_Valid=0. If any Req bit is high, arbitration selects the first set bit searching from ptr+1 upward, wrapping modulo N_REQ.
  - Latch idx, cur=Start_State[idx] and rem=Length[idx].
  - Next state is RUN if Length[idx]!=0, else DONE.
- RUN: Grant[idx]=1, Seq_Valid=1, Seq_State=cur.
  - Each cycle: cur <= cur+1 modulo 2^STATE_W (7→0 for STATE_W=3); rem <= rem-1.
  - Leave for DONE when rem==1 or Abort==1. The cycle in which Abort is sampled still emits a valid step.
- DONE (one cycle): Grant[idx]=1, Seq_Valid=0, Done[idx]=1; ptr <= idx. Next state is WAIT.
- WAIT: Grant=0, Done=0. Stay until Req[idx]==0, then go to IDLE.
- Deasserting Req[idx] during RUN has no effect; the run completes.
- Abort has no effect in IDLE, DONE or WAIT.
- Req changes by non-owners during a run have no effect; they are arbitrated only in IDLE.
- Seq_State holds its last value outside RUN. It is meaningful only while Seq_Valid is high.
- All outputs decode from registers only. There is no combinational input→output path.
- Grant and Done are never asserted for more than one requester.

## Timing
- Reset (sampled high on an edge): next cycle state=IDLE, Grant=0, Done=0, Seq_Valid=0, Seq_State=0, Ctrl_State=0, ptr=N_REQ-1 (requester 0 wins first), rem=0.
  - A reset during RUN or DONE aborts immediately and no Done pulse is produced.
- Req high at edge E0 in IDLE: Grant and the first Seq_Valid (Seq_State=start) appear in the cycle after E0.
- Length L≥1: exactly L consecutive Seq_Valid cycles, then one Done cycle.
- Length 0: no Seq_Valid; Done appears in the cycle after E0.
- Start-of-run latency: 1 cycle.
- Minimum Done→next-Grant gap: 2 cycles (WAIT, IDLE), given that the owner drops Req during the Done cycle.
- Length 15 with STATE_W=3 wraps through all 8 states and continues (start, …, start+14 mod 8).
- Abort sampled in the final RUN cycle: identical to normal completion.

## Test plan
- Reset, then Req=0001 with Start_State[0]=5 and Length[0]=4.
  - Required: Seq_State 5,6,7,0 with Seq_Valid high for 4 cycles and Grant=0001.
  - Then Done=0001 for one cycle, Ctrl_State 1→2→3→0.
- Req=1111 held, every Length=2, each owner dropping Req on its Done.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 3 cycles (2 RUN + DONE), with 2 idle cycles between grants.
- Length[2]=0, Req=0100.
  - Required: no Seq_Valid; Grant=0100 and Done=0100 in the same single cycle, one cycle after the request edge.
- Req=0001 with Length=10, start=0; assert Abort during the 3rd valid cycle.
  - Required: valid states 0,1,2 only, then Done=0001 next cycle.
- Reset asserted during the 2nd RUN cycle.
  - Required: next cycle all outputs 0 and Ctrl_State=0; no Done pulse.
  - Re-request afterwards is granted to requester 0 first.
- Owner holds Req after Done.
  - Required: Ctrl_State stays 3 and Grant=0, even with other requests pending.
  - Arbitration resumes 2 cycles after the owner drops Req.
